// File: rtl/facto_queue_core.sv
// facto_queue_core: queued factorial / double-factorial accelerator on a simple slave bus.
// Operands are pushed into an operand FIFO, processed back-to-back by a
// bit-serial shift-add multiplier FSM, and the results are collected in a result FIFO.
module facto_queue_core #(
    parameter int          DATA_W  = 64,
    parameter int          DEPTH   = 4,
    parameter logic [7:0]  BASE_HI = 8'h70
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_sel,
    input  logic        s_wr,
    input  logic [15:0] s_addr,
    input  logic [63:0] s_din,
    output logic [63:0] s_dout,
    output logic        interrupt
);

    localparam int RES_W  = 2 * DATA_W;
    localparam int PROD_W = 3 * DATA_W;
    localparam int AW     = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DATA_W);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_NEXT, S_WRITE, S_DONE} state_t;

    state_t state, state_nxt;

    // bus decode
    logic       acc_ok, wr_v, rd_v;
    logic [2:0] idx;
    logic       start_req, clear_req, push_req, pop_req;

    assign acc_ok    = s_sel && (s_addr[15:8] == BASE_HI);
    assign idx       = s_addr[5:3];
    assign wr_v      = acc_ok && s_wr;
    assign rd_v      = acc_ok && !s_wr;
    assign start_req = wr_v && (idx == 3'd0) && s_din[0];
    assign clear_req = wr_v && (idx == 3'd1) && s_din[0];
    assign push_req  = wr_v && (idx == 3'd4);
    assign pop_req   = rd_v && (idx == 3'd6);

    logic unused_bits;
    assign unused_bits = ^{s_addr[7:6], s_addr[2:0], s_din};

    // control registers
    logic              opdone, ovf, err, intr_en, mode;
    logic [DATA_W-1:0] last_op;

    // operand FIFO
    logic [DATA_W-1:0] opq_mem [DEPTH];
    logic [AW:0]       opq_wp, opq_rp, opq_cnt;
    logic              opq_empty, opq_full, opq_pop, opq_push, push_drop;
    logic [DATA_W-1:0] opq_head;

    assign opq_cnt   = opq_wp - opq_rp;
    assign opq_empty = (opq_cnt == '0);
    assign opq_full  = (opq_cnt == FULL_CNT);
    assign opq_head  = opq_mem[opq_rp[AW-1:0]];
    // A push into a full queue still lands when the FSM pops in the same cycle.
    assign opq_push  = push_req && (!opq_full || opq_pop);
    assign push_drop = push_req && opq_full && !opq_pop;

    // result FIFO
    logic [RES_W-1:0] resq_mem [DEPTH];
    logic [AW:0]      resq_wp, resq_rp, resq_cnt;
    logic             resq_empty, resq_full, resq_push, resq_pop, pop_err;
    logic [RES_W-1:0] res_head;

    assign resq_cnt   = resq_wp - resq_rp;
    assign resq_empty = (resq_cnt == '0);
    assign resq_full  = (resq_cnt == FULL_CNT);
    assign res_head   = resq_empty ? '0 : resq_mem[resq_rp[AW-1:0]];
    assign resq_pop   = pop_req && !resq_empty;
    assign pop_err    = pop_req && resq_empty;

    // multiplier datapath
    logic [DATA_W-1:0] ctr, mplier, ctr_dec;
    logic [RES_W-1:0]  acc;
    logic [PROD_W-1:0] prod, mcand, prod_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic              mul_last, ovf_hit, busy;

    assign prod_nxt = mplier[0] ? (prod + mcand) : prod;
    assign mul_last = (bit_cnt == CNT_W'(DATA_W - 1));
    assign ctr_dec  = mode ? (ctr - DATA_W'(2)) : (ctr - DATA_W'(1));
    assign ovf_hit  = (state == S_MUL) && mul_last && (|prod_nxt[PROD_W-1:RES_W]);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // FSM next-state logic; OPCLEAR overrides every other transition
    always_comb begin
        state_nxt = state;
        if (clear_req) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start_req && !opq_empty) state_nxt = S_LOAD;
                S_LOAD:  state_nxt = (opq_head <= DATA_W'(1)) ? S_WRITE : S_MUL;
                S_MUL:   if (mul_last) state_nxt = S_NEXT;
                S_NEXT:  state_nxt = (ctr_dec <= DATA_W'(1)) ? S_WRITE : S_MUL;
                S_WRITE: if (!resq_full) state_nxt = opq_empty ? S_DONE : S_LOAD;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // FSM outputs: FIFO strobes and busy flag
    always_comb begin
        busy      = (state != S_IDLE);
        opq_pop   = (state == S_LOAD) && !clear_req;
        resq_push = (state == S_WRITE) && !resq_full && !clear_req;
    end

    // operand / result FIFO pointers
    always_ff @(posedge clk) begin
        if (!reset_n || clear_req) begin
            opq_wp  <= '0;
            opq_rp  <= '0;
            resq_wp <= '0;
            resq_rp <= '0;
        end else begin
            if (opq_push)  opq_wp  <= opq_wp + (AW + 1)'(1);
            if (opq_pop)   opq_rp  <= opq_rp + (AW + 1)'(1);
            if (resq_push) resq_wp <= resq_wp + (AW + 1)'(1);
            if (resq_pop)  resq_rp <= resq_rp + (AW + 1)'(1);
        end
    end

    // FIFO storage writes
    always_ff @(posedge clk) begin
        if (opq_push)  opq_mem[opq_wp[AW-1:0]]   <= s_din[DATA_W-1:0];
        if (resq_push) resq_mem[resq_wp[AW-1:0]] <= acc;
    end

    // bit-serial shift-add multiplier and counter
    always_ff @(posedge clk) begin
        case (state)
            S_LOAD: begin
                ctr     <= opq_head;
                acc     <= RES_W'(1);
                mcand   <= PROD_W'(1);
                mplier  <= opq_head;
                prod    <= '0;
                bit_cnt <= '0;
            end
            S_MUL: begin
                prod    <= prod_nxt;
                mcand   <= mcand << 1;
                mplier  <= mplier >> 1;
                bit_cnt <= bit_cnt + CNT_W'(1);
                if (mul_last) acc <= prod_nxt[RES_W-1:0];
            end
            S_NEXT: begin
                ctr     <= ctr_dec;
                mcand   <= PROD_W'(acc);
                mplier  <= ctr_dec;
                prod    <= '0;
                bit_cnt <= '0;
            end
            default: ;
        endcase
    end

    // software-visible control and status registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            opdone  <= 1'b0;
            ovf     <= 1'b0;
            err     <= 1'b0;
            intr_en <= 1'b0;
            mode    <= 1'b0;
            last_op <= '0;
        end else if (clear_req) begin
            opdone <= 1'b0;
            ovf    <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (state == S_IDLE && start_req) opdone <= opq_empty;
            if (resq_push && opq_empty)       opdone <= 1'b1;
            if (ovf_hit)                      ovf    <= 1'b1;
            if (push_drop || pop_err)         err    <= 1'b1;
            if (wr_v && idx == 3'd3)          intr_en <= s_din[0];
            if (wr_v && idx == 3'd7)          mode    <= s_din[0];
            if (opq_push)                     last_op <= s_din[DATA_W-1:0];
        end
    end

    logic [63:0] res_h, res_l;

    generate
        if (RES_W > 64) begin : g_wide
            assign res_h = 64'(res_head[RES_W-1:64]);
            assign res_l = res_head[63:0];
        end else begin : g_narrow
            assign res_h = '0;
            assign res_l = 64'(res_head);
        end
    endgenerate

    logic [63:0] status;
    assign status = {40'd0, 8'(resq_cnt), 8'(opq_cnt), 1'b0, err, ovf,
                     resq_empty, opq_empty, opq_full, busy, opdone};

    // read mux; write-only and unselected accesses read as zero
    always_comb begin
        s_dout = '0;
        if (rd_v) begin
            case (idx)
                3'd2:    s_dout = status;
                3'd3:    s_dout = {63'd0, intr_en};
                3'd4:    s_dout = 64'(last_op);
                3'd5:    s_dout = res_h;
                3'd6:    s_dout = res_l;
                3'd7:    s_dout = {63'd0, mode};
                default: s_dout = '0;
            endcase
        end
    end

    assign interrupt = intr_en & opdone;

endmodule
